// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: Moore FSM with memory handshake and timeout watchdog.
// Define CTRL_PERF_EN to add instr/cycle/wait performance counters.
module mc_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       RegDst,
  output logic       AluSrc,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic [1:0] ALUOp,
  output logic       Jump,
  output logic       Jal,
  output logic       Jr,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic [4:0] state_o,
  output logic       fault
`ifdef CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] wait_count
`endif
);

  typedef enum logic [4:0] {
    IDLE     = 5'd0,
    FETCH    = 5'd1,
    DECODE   = 5'd2,
    EXEC_R   = 5'd3,
    WB_R     = 5'd4,
    EXEC_I   = 5'd5,
    WB_I     = 5'd6,
    MEM_ADDR = 5'd7,
    MEM_RD   = 5'd8,
    MEM_WB   = 5'd9,
    MEM_WR   = 5'd10,
    MEM_DONE = 5'd11,
    BRANCH   = 5'd12,
    JUMP     = 5'd13,
    JAL      = 5'd14,
    JR       = 5'd15,
    NOP      = 5'd16,
    FAULT    = 5'd17
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_JR, C_LW, C_SW, C_ADDI,
    C_BEQ, C_J, C_JAL, C_NOP
  } cls_t;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);
  localparam bit         WD_EN   = (MEM_TIMEOUT != 0);

  state_t     state, state_n;
  cls_t       cls, cls_d;
  logic [7:0] wcnt, wcnt_n;
  logic       op_r, fn_jr;

  assign op_r    = (OpCode == 6'b000000);
  assign fn_jr   = (funct == 6'b001000);
  assign state_o = state;

  always_comb begin
    cls_d = C_NOP;
    unique case (1'b1)
      op_r && fn_jr:          cls_d = C_JR;
      op_r && !fn_jr:         cls_d = C_R;
      OpCode == 6'b100011:    cls_d = C_LW;
      OpCode == 6'b101011:    cls_d = C_SW;
      OpCode == 6'b001000:    cls_d = C_ADDI;
      OpCode == 6'b000100:    cls_d = C_BEQ;
      OpCode == 6'b000010:    cls_d = C_J;
      OpCode == 6'b000011:    cls_d = C_JAL;
      default:                cls_d = C_NOP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cls   <= C_NOP;
      wcnt  <= 8'd0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      if (state == DECODE)
        cls <= cls_d;
    end
  end

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    case (state)
      IDLE:  state_n = FETCH;
      FETCH: state_n = DECODE;
      DECODE: begin
        unique case (cls_d)
          C_R:     state_n = EXEC_R;
          C_JR:    state_n = JR;
          C_LW:    state_n = MEM_ADDR;
          C_SW:    state_n = MEM_ADDR;
          C_ADDI:  state_n = EXEC_I;
          C_BEQ:   state_n = BRANCH;
          C_J:     state_n = JUMP;
          C_JAL:   state_n = JAL;
          default: state_n = NOP;
        endcase
      end
      EXEC_R: state_n = WB_R;
      EXEC_I: state_n = WB_I;
      MEM_ADDR: begin
        state_n = (cls == C_SW) ? MEM_WR : MEM_RD;
        wcnt_n  = 8'd0;
      end
      MEM_RD, MEM_WR: begin
        // ready on the last allowed cycle still completes the access
        if (mem_ready)
          state_n = (state == MEM_RD) ? MEM_WB : MEM_DONE;
        else if (WD_EN && wcnt == TO_LAST)
          state_n = FAULT;
        else
          wcnt_n = wcnt + 8'd1;
      end
      WB_R, WB_I, MEM_WB, MEM_DONE,
      BRANCH, JUMP, JAL, JR, NOP:
        state_n = FETCH;
      FAULT:   state_n = FAULT;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    RegDst   = 1'b0;
    AluSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    ALUOp    = 2'b00;
    Jump     = 1'b0;
    Jal      = 1'b0;
    Jr       = 1'b0;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    fault    = 1'b0;
    case (state)
      FETCH: IRWrite = 1'b1;
      EXEC_R: begin
        RegDst = 1'b1;
        ALUOp  = 2'b10;
      end
      WB_R: begin
        RegDst   = 1'b1;
        ALUOp    = 2'b10;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
      end
      EXEC_I, MEM_ADDR: AluSrc = 1'b1;
      WB_I: begin
        AluSrc   = 1'b1;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
      end
      MEM_RD: begin
        AluSrc  = 1'b1;
        MemRead = 1'b1;
      end
      MEM_WB: begin
        AluSrc   = 1'b1;
        MemRead  = 1'b1;
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
      end
      MEM_WR: begin
        AluSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      MEM_DONE: PCWrite = 1'b1;
      BRANCH: begin
        ALUOp   = 2'b01;
        Branch  = 1'b1;
        PCWrite = 1'b1;
      end
      JUMP: begin
        Jump    = 1'b1;
        PCWrite = 1'b1;
      end
      JAL: begin
        Jump     = 1'b1;
        Jal      = 1'b1;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
      end
      JR: begin
        Jump    = 1'b1;
        Jr      = 1'b1;
        PCWrite = 1'b1;
      end
      NOP:     PCWrite = 1'b1;
      FAULT:   fault = 1'b1;
      default: ;
    endcase
  end

`ifdef CTRL_PERF_EN
  logic mem_wait;
  assign mem_wait = (state == MEM_RD || state == MEM_WR) && !mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= '0;
      cycle_count <= '0;
      wait_count  <= '0;
    end else begin
      if (PCWrite)
        instr_count <= instr_count + CNT_W'(1);
      if (state != IDLE && state != FAULT)
        cycle_count <= cycle_count + CNT_W'(1);
      if (mem_wait)
        wait_count <= wait_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: instruction flows, memory waits,
// timeout fault and asynchronous reset.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] OpCode = 6'h00;
  logic [5:0] funct = 6'h20;
  logic       mem_ready = 1'b0;
  logic       RegDst, AluSrc, MemtoReg, RegWrite;
  logic       MemRead, MemWrite, Branch;
  logic [1:0] ALUOp;
  logic       Jump, Jal, Jr, PCWrite, IRWrite;
  logic [4:0] state_o;
  logic       fault;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .OpCode(OpCode), .funct(funct),
    .mem_ready(mem_ready),
    .RegDst(RegDst), .AluSrc(AluSrc),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .ALUOp(ALUOp),
    .Jump(Jump), .Jal(Jal), .Jr(Jr),
    .PCWrite(PCWrite), .IRWrite(IRWrite),
    .state_o(state_o), .fault(fault)
  );

  localparam logic [14:0] RDS  = 15'h4000;
  localparam logic [14:0] ASR  = 15'h2000;
  localparam logic [14:0] M2R  = 15'h1000;
  localparam logic [14:0] RGW  = 15'h0800;
  localparam logic [14:0] MRD  = 15'h0400;
  localparam logic [14:0] MWR  = 15'h0200;
  localparam logic [14:0] BRN  = 15'h0100;
  localparam logic [14:0] AL10 = 15'h0080;
  localparam logic [14:0] AL01 = 15'h0040;
  localparam logic [14:0] JMP  = 15'h0020;
  localparam logic [14:0] JL   = 15'h0010;
  localparam logic [14:0] JRB  = 15'h0008;
  localparam logic [14:0] PCW  = 15'h0004;
  localparam logic [14:0] IRW  = 15'h0002;
  localparam logic [14:0] FLT  = 15'h0001;

  logic [14:0] ctl;
  assign ctl = {RegDst, AluSrc, MemtoReg, RegWrite,
                MemRead, MemWrite, Branch, ALUOp,
                Jump, Jal, Jr, PCWrite, IRWrite, fault};

  task automatic chk(input string tag, input logic [14:0] exp);
    total++;
    assert (ctl === exp) passes++;
    else $error("FAIL %s: ctl=%h expected %h", tag, ctl, exp);
  endtask

  task automatic chk_st(input string tag, input logic [4:0] exp);
    total++;
    assert (state_o === exp) passes++;
    else $error("FAIL %s: state_o=%0d expected %0d", tag, state_o, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    chk("rst_ctl", 15'h0);
    chk_st("rst_state", 5'd0);
    step();
    chk("rst_hold", 15'h0);
    reset = 1'b0;

    // R-type add
    step(); chk("r_fetch", IRW);
    step(); chk("r_decode", 15'h0);
    step(); chk("r_exec", RDS | AL10);
    step(); chk("r_wb", RDS | AL10 | RGW | PCW);
    OpCode = 6'h23; funct = 6'h00;

    // lw, opcode changed after decode, two wait cycles
    step(); chk("lw_fetch", IRW);
    step(); chk("lw_decode", 15'h0);
    step(); chk("lw_addr", ASR);
    OpCode = 6'h2B;
    step(); chk("lw_rd0", ASR | MRD);
    step(); chk("lw_rd1", ASR | MRD);
    step(); chk("lw_rd2", ASR | MRD);
    mem_ready = 1'b1;
    step(); chk("lw_wb", ASR | MRD | M2R | RGW | PCW);
    mem_ready = 1'b0;
    OpCode = 6'h03;

    // jal then jr
    step(); chk("jal_fetch", IRW);
    step();
    step(); chk("jal", JMP | JL | RGW | PCW);
    OpCode = 6'h00; funct = 6'h08;
    step();
    step();
    step(); chk("jr", JMP | JRB | PCW);
    OpCode = 6'h08;

    // addi
    step();
    step();
    step(); chk("addi_ex", ASR);
    step(); chk("addi_wb", ASR | RGW | PCW);
    OpCode = 6'h04;

    // beq, j, illegal opcode
    step();
    step();
    step(); chk("beq", AL01 | BRN | PCW);
    OpCode = 6'h02;
    step();
    step();
    step(); chk("j", JMP | PCW);
    OpCode = 6'h3F;
    step();
    step();
    step(); chk("nop", PCW);
    OpCode = 6'h2B;

    // sw with ready on the last allowed cycle
    step();
    step();
    step(); chk("sw_addr", ASR);
    step(); chk("sw_wr0", ASR | MWR);
    step();
    step();
    step(); chk("sw_wr3", ASR | MWR);
    mem_ready = 1'b1;
    step(); chk("sw_done", PCW);
    mem_ready = 1'b0;

    // sw timeout
    step(); chk("swto_fetch", IRW);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      step(); chk("swto_wr", ASR | MWR);
    end
    step(); chk("swto_fault", FLT);
    OpCode = 6'h00; funct = 6'h20; mem_ready = 1'b1;
    step();
    step(); chk("fault_hold", FLT);
    #2 reset = 1'b1;
    #1 chk("fault_clr", 15'h0);
    chk_st("fault_clr_st", 5'd0);
    step();
    reset = 1'b0;
    mem_ready = 1'b0;
    OpCode = 6'h23;

    // async reset in MEM_RD
    step();
    step();
    step();
    step(); chk("mr_rd", ASR | MRD);
    #2 reset = 1'b1;
    #1 chk("mr_async", 15'h0);
    chk_st("mr_state", 5'd0);
    step();
    reset = 1'b0;
    step(); chk("mr_refetch", IRW);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
